uart_wb_tx_sequencer: RTL

//  Wishbone master that configures and feeds the simpleuart_wb slave. Buffers bytes from a

---
 rtl/uart_wb_tx_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_tx_sequencer.sv
// uart_wb_tx_sequencer
//   Wishbone master that configures and feeds a simpleuart_wb slave. Bytes arrive on a
//   valid/ready push port and are queued in a small FIFO. After reset, or whenever a new
//   divider is requested, the CLK_DIV register is written. Each queued byte is then written
//   to the DATA register. A bus cycle is held until the slave acks or the ack timeout
//   expires. Every bus cycle is followed by one idle GAP cycle.
//
// Ports
//   wb_clk_i      clock
//   wb_rst_i      synchronous reset, active-low
//   push_valid_i  byte offered on push_data_i
//   push_data_i   byte to transmit
//   push_ready_o  FIFO not full; a byte is accepted when valid & ready
//   div_i         new divider value
//   div_load_i    one-cycle pulse requesting a CLK_DIV write of div_i
//   m_wb_*        Wishbone master bus (write-only cycles)
//   busy_o        FSM not in IDLE, or FIFO not empty
//   timeout_o     sticky ack-timeout flag, cleared when a divider request is taken
//   fifo_level_o  number of bytes currently queued
//
// Optional feature
//   UART_SEQ_CRLF_EN: when defined, every 8'h0A byte is sent as 8'h0D followed by 8'h0A.

module uart_wb_tx_sequencer #(
  parameter logic [31:0] BASE_ADR    = 32'h2000_0000,
  parameter logic [7:0]  CLK_DIV_OFF = 8'h00,
  parameter logic [7:0]  DATA_OFF    = 8'h04,
  parameter logic [31:0] DEFAULT_DIV = 32'd868,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] ACK_TIMEOUT = 16'd4096
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          push_valid_i,
  input  logic [7:0]                    push_data_i,
  output logic                          push_ready_o,
  input  logic [31:0]                   div_i,
  input  logic                          div_load_i,
  output logic                          m_wb_cyc_o,
  output logic                          m_wb_stb_o,
  output logic                          m_wb_we_o,
  output logic [3:0]                    m_wb_sel_o,
  output logic [31:0]                   m_wb_adr_o,
  output logic [31:0]                   m_wb_dat_o,
  input  logic                          m_wb_ack_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {INIT, IDLE, CFG, SEND, GAP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [31:0]   div_hold;
  logic          div_pending;
  logic [15:0]   ack_cnt;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          cycle_done;
  logic [7:0]    head;
`ifdef UART_SEQ_CRLF_EN
  logic          cr_sent;
  logic          cur_is_cr;
`endif

  assign head         = fifo_mem[rd_ptr];
  assign push_ready_o = (level != LW'(FIFO_DEPTH));
  assign push         = push_valid_i & push_ready_o;
  assign fifo_level_o = level;
  assign busy_o       = (state != IDLE) || (level != '0);

  // The cycle has been open for ACK_TIMEOUT clocks when the counter reaches its last value.
  assign timeout_hit  = (ack_cnt == ACK_TIMEOUT - 16'd1);
  assign cycle_done   = ((state == CFG) || (state == SEND)) && m_wb_cyc_o &&
                        (m_wb_ack_i || timeout_hit);

  // An acked CR leaves its LF at the head; a timed-out CR drops the LF with it.
`ifdef UART_SEQ_CRLF_EN
  assign pop = (state == SEND) && cycle_done && !(cur_is_cr && m_wb_ack_i);
`else
  assign pop = (state == SEND) && cycle_done;
`endif

  // FIFO pointers and level; the level distinguishes full from empty when pointers meet.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data_i;
  end

  // Sequencer FSM. In CFG/SEND the first clock launches the registered bus cycle, which
  // then stays stable until ack or timeout closes it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= INIT;
      m_wb_cyc_o  <= 1'b0;
      m_wb_stb_o  <= 1'b0;
      m_wb_we_o   <= 1'b0;
      m_wb_sel_o  <= 4'h0;
      m_wb_adr_o  <= 32'h0;
      m_wb_dat_o  <= 32'h0;
      timeout_o   <= 1'b0;
      div_pending <= 1'b0;
      div_hold    <= 32'h0;
      ack_cnt     <= 16'h0;
`ifdef UART_SEQ_CRLF_EN
      cr_sent     <= 1'b0;
      cur_is_cr   <= 1'b0;
`endif
    end else begin
      case (state)
        INIT: begin
          div_hold <= DEFAULT_DIV;
          state    <= CFG;
        end
        IDLE: begin
          if (div_pending) begin
            div_pending <= 1'b0;
            timeout_o   <= 1'b0;
            state       <= CFG;
          end else if (level != '0) begin
            state <= SEND;
          end
        end
        CFG, SEND: begin
          if (!m_wb_cyc_o) begin
            m_wb_cyc_o <= 1'b1;
            m_wb_stb_o <= 1'b1;
            m_wb_we_o  <= 1'b1;
            ack_cnt    <= 16'h0;
            if (state == CFG) begin
              m_wb_sel_o <= 4'hF;
              m_wb_adr_o <= BASE_ADR | {24'h0, CLK_DIV_OFF};
              m_wb_dat_o <= div_hold;
            end else begin
              m_wb_sel_o <= 4'h1;
              m_wb_adr_o <= BASE_ADR | {24'h0, DATA_OFF};
`ifdef UART_SEQ_CRLF_EN
              if ((head == 8'h0A) && !cr_sent) begin
                m_wb_dat_o <= 32'h0000_000D;
                cur_is_cr  <= 1'b1;
              end else begin
                m_wb_dat_o <= {24'h0, head};
                cur_is_cr  <= 1'b0;
              end
`else
              m_wb_dat_o <= {24'h0, head};
`endif
            end
          end else if (m_wb_ack_i || timeout_hit) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            m_wb_sel_o <= 4'h0;
            m_wb_adr_o <= 32'h0;
            m_wb_dat_o <= 32'h0;
            if (!m_wb_ack_i) timeout_o <= 1'b1;
`ifdef UART_SEQ_CRLF_EN
            if (state == SEND) cr_sent <= cur_is_cr && m_wb_ack_i;
`endif
            state <= GAP;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= INIT;
      endcase
      // A divider pulse is latched in any state and overrides any earlier held value.
      if (div_load_i) begin
        div_pending <= 1'b1;
        div_hold    <= div_i;
      end
    end
  end

endmodule
